// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, FSM state and per-cycle action encodings for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int REG_ID_W = 3;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        RUN,
        LDSTALL,
        MEMWAIT,
        HALT
    } state_t;

    // What the controller does in the current cycle; drives both the outputs and the next state.
    typedef enum logic [2:0] {
        ACT_NORMAL,
        ACT_BUBBLE_START,
        ACT_BUBBLE_CONT,
        ACT_FLUSH,
        ACT_MEM_FREEZE,
        ACT_HALT_ENTRY,
        ACT_HALTED
    } action_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard check between the instruction in ID and a load in EX.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ID_W-1:0] id_rs,
    input  logic [REG_ID_W-1:0] id_rd,
    input  logic                id_rs_used,
    input  logic                id_rd_used,
    input  logic [REG_ID_W-1:0] ex_rd,
    input  logic                ex_mem_read,
    input  logic                ex_write_en,
    output logic                load_use
);

    logic rs_match;
    logic rd_match;

    assign rs_match = id_rs_used && (ex_rd == id_rs);
    assign rd_match = id_rd_used && (ex_rd == id_rd);
    assign load_use = ex_mem_read && ex_write_en && (rs_match || rd_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/freeze controller with load-use, branch, memory-wait and halt handling.
// Performance counters exist only when PIPE_CTRL_PERF_EN is defined; otherwise they read 0.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int LDUSE_STALL = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_ID_W-1:0] id_rs,
    input  logic [REG_ID_W-1:0] id_rd,
    input  logic                id_rs_used,
    input  logic                id_rd_used,
    input  logic [REG_ID_W-1:0] ex_rd,
    input  logic                ex_mem_read,
    input  logic                ex_write_en,
    input  logic                ex_branch_taken,
    input  logic                ex_halt,
    input  logic                mem_busy,
    output logic                pc_en,
    output logic                pc_load,
    output logic                ifid_en,
    output logic                ifid_flush,
    output logic                idex_bubble,
    output logic                idex_en,
    output logic                exmem_en,
    output logic                memwb_en,
    output logic                halted,
    output logic                mem_err,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t              state;
    state_t              prior_state;
    state_t              eff_state;
    action_t             act;
    logic [1:0]          stall_left;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_next;
    logic                load_use;
    logic                halted_q;
    logic                mem_err_q;

    hazard_detect u_hazard (
        .id_rs       (id_rs),
        .id_rd       (id_rd),
        .id_rs_used  (id_rs_used),
        .id_rd_used  (id_rd_used),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_write_en (ex_write_en),
        .load_use    (load_use)
    );

    // The cycle memory goes ready already behaves as the interrupted state, so no extra freeze cycle.
    assign eff_state = (state == MEMWAIT && !mem_busy) ? prior_state : state;

    assign wait_next = (state == MEMWAIT) ? wait_cnt + 1'b1 : WAIT_W'(1);

    always_comb begin
        act = ACT_NORMAL;
        if (!reset) begin
            case (eff_state)
                RUN: begin
                    if (ex_halt)              act = ACT_HALT_ENTRY;
                    else if (mem_busy)        act = ACT_MEM_FREEZE;
                    else if (ex_branch_taken) act = ACT_FLUSH;
                    else if (load_use)        act = ACT_BUBBLE_START;
                    else                      act = ACT_NORMAL;
                end
                LDSTALL: begin
                    if (mem_busy)             act = ACT_MEM_FREEZE;
                    else if (ex_branch_taken) act = ACT_FLUSH;
                    else                      act = ACT_BUBBLE_CONT;
                end
                MEMWAIT: act = ACT_MEM_FREEZE;
                HALT:    act = ACT_HALTED;
                default: act = ACT_NORMAL;
            endcase
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        pc_load     = 1'b0;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        case (act)
            ACT_BUBBLE_START, ACT_BUBBLE_CONT: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
            ACT_FLUSH: begin
                pc_load     = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            ACT_MEM_FREEZE, ACT_HALT_ENTRY, ACT_HALTED: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            prior_state <= RUN;
            stall_left  <= '0;
            wait_cnt    <= '0;
            halted_q    <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            case (act)
                ACT_NORMAL: state <= RUN;
                ACT_FLUSH: begin
                    state      <= RUN;
                    stall_left <= '0;
                end
                ACT_BUBBLE_START: begin
                    if (LDUSE_STALL > 1) begin
                        state      <= LDSTALL;
                        stall_left <= 2'(LDUSE_STALL - 1);
                    end else begin
                        state <= RUN;
                    end
                end
                ACT_BUBBLE_CONT: begin
                    if (stall_left > 2'd1) begin
                        state      <= LDSTALL;
                        stall_left <= stall_left - 1'b1;
                    end else begin
                        state      <= RUN;
                        stall_left <= '0;
                    end
                end
                ACT_MEM_FREEZE: begin
                    if (state != MEMWAIT) prior_state <= state;
                    if (wait_next >= WAIT_W'(MEM_TIMEOUT)) begin
                        state     <= HALT;
                        mem_err_q <= 1'b1;
                        halted_q  <= 1'b1;
                    end else begin
                        state    <= MEMWAIT;
                        wait_cnt <= wait_next;
                    end
                end
                ACT_HALT_ENTRY: begin
                    state    <= HALT;
                    halted_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign halted  = halted_q;
    assign mem_err = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Saturating counters; cycles spent halted are not counted as stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && state != HALT && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (ifid_flush && flush_q != '1)                flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: instances with LDUSE_STALL 1 and 3 share stimulus and are checked
// every cycle against a behavioural model, plus directed scenario end-point checks.
`timescale 1ns/1ps
module tb_pipe_ctrl;

    localparam int TIMEOUT = 15;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [9:0] NORMAL_CTRL = 10'b1010011100;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] id_rs, id_rd, ex_rd;
    logic       id_rs_used, id_rd_used, ex_mem_read, ex_write_en;
    logic       ex_branch_taken, ex_halt, mem_busy;

    wire [1:0]  pc_en, pc_load, ifid_en, ifid_flush, idex_bubble;
    wire [1:0]  idex_en, exmem_en, memwb_en, halted, mem_err;
    wire [15:0] stall_cnt [2];
    wire [15:0] flush_cnt [2];

    int testCount = 0;
    int failCount = 0;

    int stallLeft [2];
    int waitCnt   [2];
    bit waiting   [2];
    bit haltedM   [2];
    bit errM      [2];
    int stallM    [2];
    int flushM    [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_ctrl #(.MEM_TIMEOUT(TIMEOUT), .LDUSE_STALL(g == 0 ? 1 : 3)) dut (
            .clk             (clk),
            .reset           (reset),
            .id_rs           (id_rs),
            .id_rd           (id_rd),
            .id_rs_used      (id_rs_used),
            .id_rd_used      (id_rd_used),
            .ex_rd           (ex_rd),
            .ex_mem_read     (ex_mem_read),
            .ex_write_en     (ex_write_en),
            .ex_branch_taken (ex_branch_taken),
            .ex_halt         (ex_halt),
            .mem_busy        (mem_busy),
            .pc_en           (pc_en[g]),
            .pc_load         (pc_load[g]),
            .ifid_en         (ifid_en[g]),
            .ifid_flush      (ifid_flush[g]),
            .idex_bubble     (idex_bubble[g]),
            .idex_en         (idex_en[g]),
            .exmem_en        (exmem_en[g]),
            .memwb_en        (memwb_en[g]),
            .halted          (halted[g]),
            .mem_err         (mem_err[g]),
            .stall_cnt       (stall_cnt[g]),
            .flush_cnt       (flush_cnt[g])
        );
    end

    function automatic int stallLen(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [9:0] observed(input int g);
        return {pc_en[g], pc_load[g], ifid_en[g], ifid_flush[g], idex_bubble[g],
                idex_en[g], exmem_en[g], memwb_en[g], halted[g], mem_err[g]};
    endfunction

    function automatic bit loadUse();
        return ex_mem_read && ex_write_en &&
               ((id_rs_used && ex_rd == id_rs) || (id_rd_used && ex_rd == id_rd));
    endfunction

    task automatic compare(input string tag, input int g, input logic [31:0] got, input logic [31:0] want);
        testCount++;
        assert (got === want) else begin
            failCount++;
            $error("[TB] FAIL %s dut%0d observed %h expected %h", tag, g, got, want);
        end
    endtask

    task automatic modelReset();
        for (int g = 0; g < 2; g++) begin
            stallLeft[g] = 0;
            waitCnt[g]   = 0;
            waiting[g]   = 1'b0;
            haltedM[g]   = 1'b0;
            errM[g]      = 1'b0;
            stallM[g]    = 0;
            flushM[g]    = 0;
        end
    endtask

    // One cycle of intended behaviour: returns this cycle's outputs and advances the model.
    task automatic modelStep(input int g, output logic [9:0] expCtrl);
        bit pcEn, pcLoad, ifEn, ifFl, bub, rest, wasHalted, wasErr;
        pcEn = 1; pcLoad = 0; ifEn = 1; ifFl = 0; bub = 0; rest = 1;
        wasHalted = haltedM[g];
        wasErr    = errM[g];
        if (!reset) begin
            if (wasHalted) begin
                pcEn = 0; ifEn = 0; rest = 0;
            end else if (!(waiting[g] && mem_busy) && stallLeft[g] == 0 && ex_halt) begin
                pcEn = 0; ifEn = 0; rest = 0;
                haltedM[g] = 1'b1;
                waiting[g] = 1'b0;
            end else if (mem_busy) begin
                pcEn = 0; ifEn = 0; rest = 0;
                waitCnt[g] = waiting[g] ? waitCnt[g] + 1 : 1;
                waiting[g] = 1'b1;
                if (waitCnt[g] >= TIMEOUT) begin
                    errM[g]    = 1'b1;
                    haltedM[g] = 1'b1;
                    waiting[g] = 1'b0;
                end
            end else begin
                waiting[g] = 1'b0;
                if (ex_branch_taken) begin
                    pcLoad = 1; ifFl = 1; bub = 1;
                    stallLeft[g] = 0;
                end else if (stallLeft[g] > 0) begin
                    pcEn = 0; ifEn = 0; bub = 1;
                    stallLeft[g]--;
                end else if (loadUse()) begin
                    pcEn = 0; ifEn = 0; bub = 1;
                    stallLeft[g] = stallLen(g) - 1;
                end
            end
            if (!pcEn && !wasHalted && stallM[g] < 65535) stallM[g]++;
            if (ifFl && flushM[g] < 65535)                flushM[g]++;
        end
        expCtrl = {pcEn, pcLoad, ifEn, ifFl, bub, rest, rest, rest, wasHalted, wasErr};
    endtask

    task automatic checkOutput();
        logic [9:0] expCtrl;
        int expS, expF;
        @(negedge clk);
        if (reset) modelReset();
        for (int g = 0; g < 2; g++) begin
            expS = PERF ? stallM[g] : 0;
            expF = PERF ? flushM[g] : 0;
            modelStep(g, expCtrl);
            compare("ctrl", g, 32'(observed(g)), 32'(expCtrl));
            compare("stall_cnt", g, 32'(stall_cnt[g]), 32'(expS));
            compare("flush_cnt", g, 32'(flush_cnt[g]), 32'(expF));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) checkOutput();
    endtask

    task automatic clearInputs();
        id_rs = 0; id_rd = 0; ex_rd = 0;
        id_rs_used = 0; id_rd_used = 0; ex_mem_read = 0; ex_write_en = 0;
        ex_branch_taken = 0; ex_halt = 0; mem_busy = 0;
    endtask

    task automatic resetPulse();
        clearInputs();
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
    endtask

    task automatic setHazard();
        ex_mem_read = 1; ex_write_en = 1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_used = 1;
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        modelReset();
        applyStimulus(2);
        for (int g = 0; g < 2; g++) compare("reset_ctrl", g, 32'(observed(g)), 32'(NORMAL_CTRL));
        reset = 1'b0;
        applyStimulus(2);

        // Single load-use hazard.
        resetPulse();
        setHazard();
        applyStimulus(1);
        clearInputs();
        applyStimulus(4);
        compare("s1_stall", 0, 32'(stall_cnt[0]), PERF ? 32'd1 : 32'd0);
        compare("s1_stall", 1, 32'(stall_cnt[1]), PERF ? 32'd3 : 32'd0);

        // Branch wins over a simultaneous load-use.
        resetPulse();
        setHazard();
        ex_branch_taken = 1;
        applyStimulus(1);
        clearInputs();
        applyStimulus(2);
        for (int g = 0; g < 2; g++) begin
            compare("s2_flush", g, 32'(flush_cnt[g]), PERF ? 32'd1 : 32'd0);
            compare("s2_stall", g, 32'(stall_cnt[g]), 32'd0);
        end

        // Memory wait interrupting a multi-cycle load-use stall.
        resetPulse();
        setHazard();
        applyStimulus(1);
        clearInputs();
        mem_busy = 1;
        applyStimulus(4);
        mem_busy = 0;
        applyStimulus(4);
        compare("s3_stall", 0, 32'(stall_cnt[0]), PERF ? 32'd5 : 32'd0);
        compare("s3_stall", 1, 32'(stall_cnt[1]), PERF ? 32'd7 : 32'd0);

        // Memory timeout.
        resetPulse();
        mem_busy = 1;
        applyStimulus(TIMEOUT);
        mem_busy = 0;
        applyStimulus(5);
        for (int g = 0; g < 2; g++)
            compare("s4_err_halt", g, 32'({halted[g], mem_err[g], pc_en[g], idex_en[g], memwb_en[g]}), 32'b11000);

        // Halt beats a taken branch; reset recovers.
        resetPulse();
        ex_halt = 1;
        ex_branch_taken = 1;
        applyStimulus(1);
        clearInputs();
        applyStimulus(3);
        for (int g = 0; g < 2; g++) compare("s5_halted", g, 32'(halted[g]), 32'd1);
        resetPulse();
        for (int g = 0; g < 2; g++) begin
            compare("s5_ctrl", g, 32'(observed(g)), 32'(NORMAL_CTRL));
            compare("s5_cnt", g, 32'({stall_cnt[g], flush_cnt[g]}), 32'd0);
        end

        // Ten consecutive flushes.
        resetPulse();
        ex_branch_taken = 1;
        applyStimulus(10);
        clearInputs();
        applyStimulus(1);
        for (int g = 0; g < 2; g++)
            compare("s6_flush", g, 32'(flush_cnt[g]), PERF ? 32'd10 : 32'd0);

        // Random traffic with occasional resets.
        resetPulse();
        for (int i = 0; i < 400; i++) begin
            id_rs           = 3'($urandom_range(0, 3));
            id_rd           = 3'($urandom_range(0, 3));
            ex_rd           = 3'($urandom_range(0, 3));
            id_rs_used      = 1'($urandom_range(0, 1));
            id_rd_used      = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 2) != 0);
            ex_write_en     = ($urandom_range(0, 3) != 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            ex_halt         = ($urandom_range(0, 59) == 0);
            mem_busy        = ($urandom_range(0, 4) == 0);
            reset           = ($urandom_range(0, 79) == 0) || (haltedM[0] && haltedM[1]);
            applyStimulus(1);
        end
        reset = 1'b0;
        clearInputs();
        applyStimulus(2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max MEMWAIT cycles before error.
REQ-002 SHALL have parameter LDUSE_STALL, default 1, bubble cycles inserted per load-use hazard (1..3).
REQ-003 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- id_rs, id_rd  in  3 each  register IDs of the instruction in ID.
- id_rs_used, id_rd_used  in  1 each  ID instruction reads that register.
- ex_rd  in  3  destination ID in EX.
- ex_mem_read, ex_write_en  in  1 each  EX instruction is a load / writes a register.
- ex_branch_taken  in  1  EX resolved a taken branch.
- ex_halt  in  1  halt instruction in EX.
- mem_busy  in  1  data memory not ready.
- pc_en, pc_load  out  1 each  PC advance / redirect to branch target.
- ifid_en, ifid_flush  out  1 each  IF/ID hold / clear.
- idex_bubble  out  1  selects zeroed controls into ID/EX.
- idex_en, exmem_en, memwb_en  out  1 each  register enables.
- halted, mem_err  out  1 each  sticky status.
- stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-004 SHALL implement FSM states RUN, LDSTALL, MEMWAIT, HALT.
REQ-005 In RUN with no event: pc_en, ifid_en, idex_en, exmem_en, memwb_en = 1; all other control outputs = 0.
REQ-006 Load-use hazard SHALL be ex_mem_read & ex_write_en & ((id_rs_used & ex_rd==id_rs) | (id_rd_used & ex_rd==id_rd)).
REQ-007 Event priority in RUN: ex_halt > mem_busy > ex_branch_taken > load-use.
REQ-008 Load-use in RUN: same cycle pc_en=0, ifid_en=0, idex_bubble=1; if LDUSE_STALL>1, enter LDSTALL and repeat the same outputs for LDUSE_STALL-1 further cycles, then return to RUN.
REQ-009 Taken branch in RUN: same cycle pc_load=1, ifid_flush=1, idex_bubble=1; stay in RUN; a simultaneous load-use is discarded.
REQ-010 Taken branch while in LDSTALL SHALL abort the stall, apply REQ-009 outputs, and go to RUN.
REQ-011 mem_busy in RUN or LDSTALL: all enables=0, bubble/flush/load=0 (full freeze), enter MEMWAIT; the LDSTALL remaining count SHALL be preserved and resumed after the wait.
REQ-012 MEMWAIT: hold freeze; on mem_busy=0 return to the prior state the next cycle; the wait counter increments each busy cycle.
REQ-013 Wait counter reaching MEM_TIMEOUT SHALL set mem_err and enter HALT.
REQ-014 ex_halt in RUN: enter HALT; in HALT all enables=0, halted=1; leave only by reset.
REQ-015 stall_cnt SHALL increment on each cycle with pc_en=0 outside HALT; flush_cnt on each cycle with ifid_flush=1; both saturate at 16'hFFFF.

Reset
REQ-016 Reset SHALL force RUN, clear counters, mem_err, halted and stall count; outputs take REQ-005 values during reset.
REQ-017 Reset asserted in MEMWAIT or HALT SHALL return to RUN with no residual freeze.

Configuration
REQ-018 With PIPE_CTRL_PERF_EN defined, stall_cnt and flush_cnt SHALL operate per REQ-015.
REQ-019 Without PIPE_CTRL_PERF_EN, the counter registers SHALL not exist, and both outputs SHALL be constant 0 with ports retained.

Structure
REQ-020 Package pipe_ctrl_pkg SHALL hold the state enum, REG_ID_W=3 and CNT_W=16.
REQ-021 Sub-module hazard_detect SHALL implement REQ-006 combinationally; the FSM and counters SHALL reside in pipe_ctrl.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- ex_mem_read=1, ex_write_en=1, ex_rd=3, id_rs=3, id_rs_used=1, LDUSE_STALL=1 -> one cycle with pc_en=0, idex_bubble=1; RUN next; stall_cnt=1.
- Same hazard plus ex_branch_taken=1 -> pc_load=1, ifid_flush=1, idex_bubble=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- LDUSE_STALL=3, hazard, then mem_busy for 4 cycles in 2nd stall cycle -> 4 freeze cycles, then 2 remaining bubble cycles (including the resumed one); stall_cnt=7.
- mem_busy held 15 cycles -> mem_err=1, halted=1, all enables=0; stays until reset.
- ex_halt=1 with ex_branch_taken=1 -> HALT, pc_load=0; reset pulse -> RUN, counters 0.
- Build without PIPE_CTRL_PERF_EN, run 10 flushes -> flush_cnt reads 0.
